// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out stage with a valid/ready intake.
//
// Each accepted WIDTH-bit word is shifted out one bit per clock. The first bit
// appears on the cycle after the accept. The frame's final bit is flagged with
// last. A new word may be accepted on the last-bit edge, so frames stream
// back to back with no idle cycle.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   defined   - an even-parity bit (XOR of the word, captured at accept) is
//               appended after the data bits; frame length is WIDTH+1.
//   undefined - no parity storage or logic; frame length is WIDTH.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   d           parallel word from upstream
//   d_valid     word on d is valid
//   d_ready     word is taken on this edge when d_valid=1 (combinational)
//   sout        serial data bit (registered)
//   sout_valid  sout carries a frame bit this cycle (registered)
//   last        sout is the final bit of the frame (registered)
//   busy        frame in progress (registered)
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   shifted;
    logic               head_bit;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Ready only in IDLE or while the final bit of a frame is on the output,
    // which is what allows zero-gap streaming.
    assign d_ready = (state_q == StIdle) || ((state_q == StShift) && last_q);
    assign accept  = d_valid && d_ready;

    // Shift toward the output end; the vacated end fills with 0.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    load    = 1'b1;
                end
            end
            StShift: begin
                if (last_q) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
        if (load) begin
            shreg_d = d;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^d;
`endif
        end
    end

    // Registered outputs are computed from the next state so they line up
    // with the shift register contents of the following cycle.
    always_comb begin
        head_bit     = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
        busy_d       = (state_d == StShift);
        sout_valid_d = (state_d == StShift);
        last_d       = (state_d == StShift) && (cnt_d == LAST_IDX);
        sout_d       = 1'b0;
        if (state_d == StShift) begin
`ifdef PISO_PARITY_EN
            sout_d = (cnt_d == CNT_W'(WIDTH)) ? parity_d : head_bit;
`else
            sout_d = head_bit;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share
// the same stimulus. A queue of pending serial bits per instance is the
// reference: an accepted word appends its frame bits, each clock in a frame
// consumes the front bit.
module tb_piso_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d;
    logic         d_valid;

    logic rdy_m, sout_m, sv_m, last_m, busy_m;
    logic rdy_l, sout_l, sv_l, last_l, busy_l;

    int tests = 0;
    int fails = 0;
    bit known = 1'b0;
    bit q_m[$];
    bit q_l[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_valid    (d_valid),
        .d_ready    (rdy_m),
        .sout       (sout_m),
        .sout_valid (sv_m),
        .last       (last_m),
        .busy       (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_valid    (d_valid),
        .d_ready    (rdy_l),
        .sout       (sout_l),
        .sout_valid (sv_l),
        .last       (last_l),
        .busy       (busy_l)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check d_ready, clock, update model, check outputs.
    task automatic step(input logic r, input logic [W-1:0] dw, input logic dv,
                        output logic acc);
        logic exp_rdy;
        rst     = r;
        d       = dw;
        d_valid = dv;
        #1;
        // Ready when no frame is pending or only its final bit is showing.
        exp_rdy = (q_m.size() <= 1);
        if (known) begin
            check("d_ready_msb", rdy_m, exp_rdy);
            check("d_ready_lsb", rdy_l, exp_rdy);
        end
        acc = r && dv && exp_rdy;
        @(posedge clk);
        if (!r) begin
            q_m.delete();
            q_l.delete();
            known = 1'b1;
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (acc) begin
                for (int i = W - 1; i >= 0; i--) q_m.push_back(dw[i]);
                for (int i = 0; i < W; i++) q_l.push_back(dw[i]);
`ifdef PISO_PARITY_EN
                q_m.push_back(^dw);
                q_l.push_back(^dw);
`endif
            end
        end
        #1;
        check("sout_valid_msb", sv_m, q_m.size() > 0);
        check("busy_msb", busy_m, q_m.size() > 0);
        check("last_msb", last_m, q_m.size() == 1);
        check("sout_msb", sout_m, (q_m.size() > 0) ? q_m[0] : 1'b0);
        check("sout_valid_lsb", sv_l, q_l.size() > 0);
        check("busy_lsb", busy_l, q_l.size() > 0);
        check("last_lsb", last_l, q_l.size() == 1);
        check("sout_lsb", sout_l, (q_l.size() > 0) ? q_l[0] : 1'b0);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0, acc);
    endtask

    // Offer a word and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] w);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 2 * W + 4 && !acc; i++) step(1'b1, w, 1'b1, acc);
        check("send_accepted", acc, 1'b1);
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] w;
        logic         dv;
        bit           hold;

        // Reset then idle.
        step(1'b0, '0, 1'b0, acc);
        step(1'b0, '0, 1'b0, acc);
        idle(2);

        // Single word 1100, then return to idle.
        send(4'b1100);
        idle(5);

        // Back-to-back 1101 then 0100 with d_valid held high.
        send(4'b1101);
        send(4'b0100);
        idle(5);

        // Words from the LSB-first plan (checked on both instances).
        send(4'b0011);
        idle(5);
        send(4'b1110);
        idle(5);

        // Reset mid-frame after the 2nd bit; nothing resumes afterwards.
        send(4'b1111);
        idle(1);
        step(1'b0, '0, 1'b0, acc);
        idle(6);

        // Reset together with d_valid: word is not taken.
        step(1'b0, 4'b1010, 1'b1, acc);
        idle(3);

        // Parity-plan words.
        send(4'b1101);
        idle(6);
        send(4'b1100);
        idle(6);

        // Random traffic with occasional resets; words held until accepted.
        hold = 1'b0;
        w    = '0;
        dv   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic r;
            if (!hold) begin
                w  = W'($urandom);
                dv = ($urandom_range(0, 9) < 7);
            end
            r = ($urandom_range(0, 39) != 0);
            step(r, w, dv, acc);
            hold = dv && !acc;
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
